// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter checker: FSM encoding and error-counter width.
package counter_checker_pkg;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_checker_model_step.sv
// Reference next-state function of the monitored counter (pure combinational).
module counter_model_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur_count,
    input  logic             cur_ovf,
    input  logic             mon_reset,
    input  logic             mon_enable,
    output logic [WIDTH-1:0] next_count,
    output logic             next_ovf
);

    always_comb begin
        next_count = cur_count;
        if (!mon_reset && mon_enable) begin
            next_count = cur_count + 1'b1;
        end

        // Reaching all-ones sets overflow even while mon_reset is asserted.
        if (cur_count == '1) begin
            next_ovf = 1'b1;
        end else if (mon_reset) begin
            next_ovf = 1'b0;
        end else begin
            next_ovf = cur_ovf;
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Shadows a monitored counter with a model and reports mismatches against it.
//  state | meaning
//  IDLE  | disarmed, no checking
//  SYNC  | one cycle: seed the model from the observed counter
//  TRACK | compare every cycle, resync the model after each fault
//  FAIL  | frozen after the first fault (STOP_ON_ERROR only)
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arm,
    input  logic             mon_reset,
    input  logic             mon_enable,
    input  logic [WIDTH-1:0] dut_count,
    input  logic             dut_overflow,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic             fail,
    output logic [WIDTH:0]   first_exp,
    output logic [WIDTH:0]   first_obs,
    output logic             tracking
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_count_q, exp_count_d;
    logic             exp_ovf_q, exp_ovf_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             fail_q, fail_d;
    logic [WIDTH:0]   first_exp_q, first_exp_d;
    logic [WIDTH:0]   first_obs_q, first_obs_d;

    logic             mismatch_now;
    logic             use_obs;
    logic [WIDTH-1:0] base_count;
    logic             base_ovf;
    logic [WIDTH-1:0] step_count;
    logic             step_ovf;

    assign mismatch_now = (state_q == ST_TRACK) &&
                          ((dut_count != exp_count_q) || (dut_overflow != exp_ovf_q));

    // SYNC always seeds from the observed value; TRACK only does so after a fault.
    assign use_obs    = (state_q != ST_TRACK) || mismatch_now;
    assign base_count = use_obs ? dut_count    : exp_count_q;
    assign base_ovf   = use_obs ? dut_overflow : exp_ovf_q;

    counter_model_step #(.WIDTH(WIDTH)) u_model_step (
        .cur_count  (base_count),
        .cur_ovf    (base_ovf),
        .mon_reset  (mon_reset),
        .mon_enable (mon_enable),
        .next_count (step_count),
        .next_ovf   (step_ovf)
    );

    always_comb begin
        state_d     = state_q;
        exp_count_d = exp_count_q;
        exp_ovf_d   = exp_ovf_q;
        mismatch_d  = 1'b0;
        err_count_d = err_count_q;
        fail_d      = fail_q;
        first_exp_d = first_exp_q;
        first_obs_d = first_obs_q;

        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: begin
                    exp_count_d = step_count;
                    exp_ovf_d   = step_ovf;
                    state_d     = ST_TRACK;
                end
                ST_TRACK: begin
                    exp_count_d = step_count;
                    exp_ovf_d   = step_ovf;
                    if (mismatch_now) begin
                        mismatch_d = 1'b1;
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (!fail_q) begin
                            fail_d      = 1'b1;
                            first_exp_d = {exp_ovf_q, exp_count_q};
                            first_obs_d = {dut_overflow, dut_count};
                        end
                        if (STOP_ON_ERROR) begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            exp_count_q <= '0;
            exp_ovf_q   <= 1'b0;
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
            fail_q      <= 1'b0;
            first_exp_q <= '0;
            first_obs_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_count_q <= exp_count_d;
            exp_ovf_q   <= exp_ovf_d;
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
            fail_q      <= fail_d;
            first_exp_q <= first_exp_d;
            first_obs_q <= first_obs_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign err_count = err_count_q;
    assign fail      = fail_q;
    assign first_exp = first_exp_q;
    assign first_obs = first_obs_q;
    assign tracking  = (state_q == ST_TRACK);

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the monitored counter width.
REQ-002 Parameter STOP_ON_ERROR, default 0; when 1, the first mismatch SHALL freeze checking in FAIL.
REQ-003 clock  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high; clears the checker only, never the monitored counter.
REQ-005 arm  input  1  level; 1 starts/continues checking, 0 returns to IDLE.
REQ-006 mon_reset  input  1  copy of the monitored counter's reset.
REQ-007 mon_enable  input  1  copy of the monitored counter's enable.
REQ-008 dut_count  input  WIDTH  observed counter value.
REQ-009 dut_overflow  input  1  observed overflow flag.
REQ-010 mismatch  output  1  one-cycle pulse per detected mismatch.
REQ-011 err_count  output  8  saturating mismatch total.
REQ-012 fail  output  1  sticky; set on first mismatch.
REQ-013 first_exp  output  WIDTH+1  {expected overflow, expected count} at first mismatch.
REQ-014 first_obs  output  WIDTH+1  {dut_overflow, dut_count} at first mismatch.
REQ-015 tracking  output  1  high while in TRACK.

Function
REQ-016 The model counter SHALL be defined as:
- count: next = count+1 mod 2^WIDTH if !mon_reset && mon_enable; otherwise hold (mon_reset SHALL NOT clear count).
- overflow: next = 1 if count == all-ones (overrides mon_reset); else 0 if mon_reset; else hold.
REQ-017 FSM states SHALL be IDLE, SYNC, TRACK, FAIL.
REQ-018 IDLE -> SYNC when arm=1; any state -> IDLE when arm=0 (checked before all other transitions).
REQ-019 SYNC (exactly 1 cycle) SHALL load exp_count/exp_ovf = F(dut_count, dut_overflow, mon_reset, mon_enable) with no comparison, then -> TRACK.
REQ-020 TRACK, each cycle: mismatch_now = (dut_count != exp_count) || (dut_overflow != exp_ovf).
REQ-021 TRACK SHALL set base = mismatch_now ? observed : expected, and load exp = F(base, current mon_reset, mon_enable), resyncing the model so that one fault yields one mismatch.
REQ-022 mismatch SHALL assert the cycle after mismatch_now (one-cycle latency); back-to-back mismatches SHALL give back-to-back pulses.
REQ-023 err_count SHALL increment per mismatch and saturate at 255.
REQ-024 On the first mismatch since reset, fail SHALL set and first_exp/first_obs SHALL capture, then hold until reset; later mismatches SHALL NOT overwrite them.
REQ-025 If STOP_ON_ERROR=1, the first mismatch SHALL move TRACK -> FAIL; FAIL SHALL NOT compare or pulse mismatch, and exits only on arm=0 or reset.
REQ-026 Wrap: expected all-ones with mon_enable=1 SHALL yield next expected count 0 and exp_ovf=1.
REQ-027 fail/err_count/first_* SHALL persist across arm toggling; only reset clears them.

Reset
REQ-028 On reset: state=IDLE, mismatch=0, err_count=0, fail=0, first_exp=0, first_obs=0, tracking=0, exp_count=0, exp_ovf=0.
REQ-029 reset SHALL take priority over arm in the same cycle.
REQ-030 reset asserted mid-TRACK SHALL suppress the mismatch pulse from the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2 bits) and the err_count width constant (8).
REQ-032 The model next-state function F SHALL be one sub-module, counter_model_step (combinational, WIDTH-parameterised), instantiated once.

Verification
REQ-033 arm=1, mon_enable=1 for 20 cycles, correct counter from 0 -> mismatch never asserts, and tracking=1 from cycle 2.
REQ-034 Correct counter 14->15->0 -> exp_ovf=1 after 15, no mismatch; then mon_reset=1 with count=3 -> overflow expected 0, count held at 3.
REQ-035 Inject dut_count=9 where 6 is expected -> exactly one mismatch pulse; err_count=1; first_exp=5'b0_0110; first_obs=5'b0_1001; no further mismatches as counting continues from 9.
REQ-036 STOP_ON_ERROR=1, inject an error -> FAIL entered, later errors give no pulses, err_count stays 1; arm=0 then 1 -> SYNC, then TRACK.
REQ-037 Force 300 consecutive mismatches -> err_count saturates at 255; first_* equal the first fault's values.
REQ-038 Assert reset during a mismatch cycle in TRACK -> no pulse, all outputs zero, state IDLE next cycle.
